// File: rtl/char_rotator_mux.sv
// char_rotator_mux
// Holds NUM_CH character codes and drives every display position from a
// rotating select offset, so the message scrolls left or right. The offset
// advances on an internal prescaled tick or on a manual step request.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   load      capture char_in into the character registers
//   char_in   new message, character k at [k*CODE_W +: CODE_W]
//   mode      00 HOLD, 01 LEFT, 10 RIGHT, 11 CLEAR
//   step      manual advance request, one advance per cycle it is high
//   disp_out  registered code for position i at [i*CODE_W +: CODE_W]
//   offset    current rotation offset, 0..NUM_CH-1
//   tick_out  one-cycle pulse per prescaler tick (registered)
//   wrap      one-cycle pulse when the offset wraps, aligned with the new offset
module char_rotator_mux #(
  parameter int CODE_W   = 3,
  parameter int NUM_CH   = 8,
  parameter int SEL_W    = 3,
  parameter int TICK_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [NUM_CH*CODE_W-1:0] char_in,
  input  logic [1:0]               mode,
  input  logic                     step,
  output logic [NUM_CH*CODE_W-1:0] disp_out,
  output logic [SEL_W-1:0]         offset,
  output logic                     tick_out,
  output logic                     wrap
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] OFF_LAST = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  logic [CODE_W-1:0] char_reg [NUM_CH];
  logic [CODE_W-1:0] disp_reg [NUM_CH];
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SEL_W-1:0]  offset_reg, offset_next;
  logic              tick_reg, tick_next;
  logic              wrap_reg, wrap_next;
  logic              tick;
  logic              advance;

  // Prescaler, offset, tick and wrap next-state.
  always_comb begin
    tick        = (cnt_reg == CNT_LAST);
    advance     = tick | step;
    cnt_next    = tick ? '0 : cnt_reg + 1'b1;
    offset_next = offset_reg;
    tick_next   = tick;
    wrap_next   = 1'b0;
    if (load || mode_sel == MODE_CLEAR) begin
      // Both restart the scroll from an unrotated message and a fresh prescaler.
      offset_next = '0;
      cnt_next    = '0;
      tick_next   = 1'b0;
    end else if (mode_sel == MODE_LEFT && advance) begin
      if (offset_reg == OFF_LAST) begin
        offset_next = '0;
        wrap_next   = 1'b1;
      end else begin
        offset_next = offset_reg + 1'b1;
      end
    end else if (mode_sel == MODE_RIGHT && advance) begin
      if (offset_reg == '0) begin
        offset_next = OFF_LAST;
        wrap_next   = 1'b1;
      end else begin
        offset_next = offset_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      offset_reg <= '0;
      tick_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      offset_reg <= offset_next;
      tick_reg   <= tick_next;
      wrap_reg   <= wrap_next;
    end
  end

  // Per-position character storage and rotated display register.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pos
      logic [SEL_W:0]   idx_sum;
      logic [SEL_W:0]   idx_mod;

      // (gi + offset) mod NUM_CH; the sum is below 2*NUM_CH so one
      // conditional subtract is enough, and it works for any NUM_CH.
      assign idx_sum = (SEL_W+1)'(gi) + {1'b0, offset_reg};
      assign idx_mod = (idx_sum >= (SEL_W+1)'(NUM_CH)) ?
                       idx_sum - (SEL_W+1)'(NUM_CH) : idx_sum;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          char_reg[gi] <= '0;
          disp_reg[gi] <= '0;
        end else begin
          if (load) begin
            char_reg[gi] <= char_in[gi*CODE_W +: CODE_W];
          end
          disp_reg[gi] <= char_reg[idx_mod[SEL_W-1:0]];
        end
      end

      assign disp_out[gi*CODE_W +: CODE_W] = disp_reg[gi];
    end
  endgenerate

  assign offset   = offset_reg;
  assign tick_out = tick_reg;
  assign wrap     = wrap_reg;

endmodule

// File: tb/tb_char_rotator_mux.sv
module tb_char_rotator_mux;

  logic        clk = 1'b0;
  logic        rst_n, load, step;
  logic [1:0]  mode;
  logic [23:0] c8;
  logic [14:0] c5;
  assign c5 = c8[14:0];

  logic [23:0] d8;
  logic [2:0]  o8;
  logic        t8, w8;
  logic [14:0] d5;
  logic [2:0]  o5;
  logic        t5, w5;

  always #5 clk = ~clk;

  char_rotator_mux #(.CODE_W(3), .NUM_CH(8), .SEL_W(3), .TICK_DIV(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .load(load), .char_in(c8), .mode(mode),
    .step(step), .disp_out(d8), .offset(o8), .tick_out(t8), .wrap(w8));

  char_rotator_mux #(.CODE_W(3), .NUM_CH(5), .SEL_W(3), .TICK_DIV(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .load(load), .char_in(c5), .mode(mode),
    .step(step), .disp_out(d5), .offset(o5), .tick_out(t5), .wrap(w5));

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 is the 8-character unit, index 1 the 5-character one.
  int          nch [2] = '{8, 5};
  int          m_chars [2][8];
  int          m_off [2];
  int          m_cnt [2];
  int          m_tick [2];
  int          m_wrap [2];
  logic [23:0] m_disp [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 8; k++) m_chars[u][k] = 0;
      m_off[u] = 0; m_cnt[u] = 0; m_tick[u] = 0; m_wrap[u] = 0; m_disp[u] = '0;
    end
  endtask

  // One rising edge of the model, using the inputs present before the edge.
  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      int n = nch[u];
      logic [23:0] nd = '0;
      bit tk, adv;
      for (int i = 0; i < n; i++)
        nd = nd | (24'(m_chars[u][(i + m_off[u]) % n]) << (3 * i));
      tk  = (m_cnt[u] == 3);
      adv = tk || step;
      m_wrap[u] = 0;
      if (load) begin
        for (int k = 0; k < n; k++) m_chars[u][k] = int'(c8[3*k +: 3]);
        m_off[u] = 0; m_cnt[u] = 0; m_tick[u] = 0;
      end else if (mode == 2'b11) begin
        m_off[u] = 0; m_cnt[u] = 0; m_tick[u] = 0;
      end else begin
        m_cnt[u]  = (m_cnt[u] + 1) % 4;
        m_tick[u] = tk;
        if (mode == 2'b01 && adv) begin
          m_wrap[u] = (m_off[u] == n - 1);
          m_off[u]  = (m_off[u] + 1) % n;
        end else if (mode == 2'b10 && adv) begin
          m_wrap[u] = (m_off[u] == 0);
          m_off[u]  = (m_off[u] + n - 1) % n;
        end
      end
      m_disp[u] = nd;
    end
  endtask

  task automatic compare_all();
    chk("disp8",   32'(d8), 32'(m_disp[0]));
    chk("offset8", 32'(o8), 32'(m_off[0]));
    chk("tick8",   32'(t8), 32'(m_tick[0]));
    chk("wrap8",   32'(w8), 32'(m_wrap[0]));
    chk("disp5",   32'(d5), 32'(m_disp[1][14:0]));
    chk("offset5", 32'(o5), 32'(m_off[1]));
    chk("tick5",   32'(t5), 32'(m_tick[1]));
    chk("wrap5",   32'(w5), 32'(m_wrap[1]));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int tcount, wcount;
    bit found;
    model_reset();
    rst_n = 1'b0; load = 1'b0; mode = 2'b00; step = 1'b0; c8 = 24'($urandom);

    // Reset with random char_in: everything zero.
    cyc(); cyc();
    chk("reset_disp8", 32'(d8), 32'h0);
    chk("reset_offset8", 32'(o8), 32'h0);
    rst_n = 1'b1;

    // Load {7..0}; two cycles later the message is shown unrotated.
    c8 = 24'o76543210; load = 1'b1;
    cyc();
    load = 1'b0; c8 = 24'($urandom);
    cyc();
    chk("load_disp8", 32'(d8), 32'(24'o76543210));
    chk("load_offset8", 32'(o8), 32'h0);

    // CLEAR restarts the prescaler, then 32 LEFT cycles: 8 ticks, one wrap.
    mode = 2'b11; cyc();
    mode = 2'b01; tcount = 0; wcount = 0;
    repeat (32) begin
      cyc();
      tcount += int'(t8); wcount += int'(w8);
    end
    chk("left_ticks8", 32'(tcount), 32'd8);
    chk("left_wraps8", 32'(wcount), 32'd1);
    chk("left_offset8", 32'(o8), 32'd0);
    chk("left_offset5", 32'(o5), 32'd3);

    // RIGHT with a step and no tick pending: 0 -> 7 with wrap.
    mode = 2'b10; step = 1'b1; cyc();
    step = 1'b0;
    chk("right_offset8", 32'(o8), 32'd7);
    chk("right_wrap8", 32'(w8), 32'd1);
    mode = 2'b00; cyc();
    chk("right_pos0_8", 32'(d8[2:0]), 32'd7);

    // Async reset mid-scroll at offset 3.
    mode = 2'b01; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (o8 == 3'd3) found = 1;
    end
    chk("reach_offset3", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    chk("async_disp8", 32'(d8), 32'h0);
    cyc();
    rst_n = 1'b1;

    // Randomised traffic; load and step can coincide with ticks.
    c8 = 24'($urandom); load = 1'b1; cyc(); load = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      step = ($urandom_range(0, 3) == 0);
      load = ($urandom_range(0, 31) == 0);
      c8   = 24'($urandom);
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_rotator_mux.md
Name: char_rotator_mux

Overview:
Parametrised successor of the 3-bit 8-to-1 character-code multiplexer used on the message display. Holds NUM_CH character codes in registers and drives all NUM_CH display positions from a rotating select offset. The offset advances on an internal prescaled tick or a manual step, scrolling the message left or right. Sits between the switch/ROM message source and the per-digit code-to-7-segment decoders.

Parameters:
CODE_W, 3, bits per character code
NUM_CH, 8, number of characters and display positions; any value 2..16, not necessarily a power of two
SEL_W, 3, offset width, equal to ceil(log2(NUM_CH))
TICK_DIV, 25000000, Clock cycles per scroll tick; minimum 2

Ports:
Clock  in  1  system clock; all state changes on the rising edge
Resetn  in  1  asynchronous active-low reset
load  in  1  capture char_in into the character registers
char_in  in  NUM_CH*CODE_W  new message; character k is at bits [k*CODE_W +: CODE_W]
mode  in  2  00 HOLD, 01 LEFT, 10 RIGHT, 11 CLEAR
step  in  1  single-cycle manual advance request
disp_out  out  NUM_CH*CODE_W  code for display position i at [i*CODE_W +: CODE_W]; registered
offset  out  SEL_W  current rotation offset, range 0..NUM_CH-1
tick_out  out  1  one-cycle pulse on each prescaler tick
wrap  out  1  one-cycle pulse when offset wraps (NUM_CH-1 to 0 in LEFT, 0 to NUM_CH-1 in RIGHT)

Behaviour:
- Reset (Resetn=0, asynchronous): character registers = 0, offset = 0, prescaler = 0, disp_out = 0, tick_out = 0, wrap = 0. Reset asserted mid-scroll clears all state immediately. After release, counting restarts from 0.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick is asserted on the cycle the count equals TICK_DIV-1. tick_out is registered, so it pulses one cycle after that count.
- Advance event = tick OR step. A tick and a step in the same cycle produce a single advance of 1.
- Priority per cycle, highest first:
  1. load: capture char_in, set offset to 0, clear the prescaler, suppress any advance and wrap. load has this effect in every mode.
  2. mode CLEAR: set offset to 0 and clear the prescaler. Character registers are kept. tick_out stays 0.
  3. mode LEFT with an advance event: offset = offset+1, or 0 if offset = NUM_CH-1 (wrap pulses).
  4. mode RIGHT with an advance event: offset = offset-1, or NUM_CH-1 if offset = 0 (wrap pulses).
  5. mode HOLD: offset is held and step is ignored. The prescaler keeps running and tick_out keeps pulsing.
- The offset wraps explicitly at NUM_CH, not at 2^SEL_W. It never exceeds NUM_CH-1.
- disp_out position i = char[(i+offset) mod NUM_CH], computed from the current registers and registered.
  - Latency is 1 cycle from any offset or character-register update to disp_out.
  - load, then 2 cycles later disp_out shows char_in unrotated.
- wrap is registered and aligned with the cycle in which the new offset becomes visible.
- A mode change takes effect on the next edge. The prescaler is not reset on a mode change, except for CLEAR.
- step is edge-agnostic: each cycle it is high counts as one request. A debounced single-cycle pulse is the upstream's responsibility.

Test Plan:
Use TICK_DIV=4, NUM_CH=8, CODE_W=3 unless stated.
- Reset/load: Resetn low with char_in random → all outputs 0. Release, load char_in = {7,6,5,4,3,2,1,0} (position 0 = 0) → two cycles later disp_out positions 0..7 = 0..7 and offset = 0.
- LEFT scroll: mode=01 for 32 cycles → offset 1,2,...,7,0 at 4-cycle spacing. Position 0 shows 1 after the first tick. wrap pulses once, when offset returns to 0. tick_out pulses 8 times.
- RIGHT and step: mode=10 with no tick pending, step pulse → offset 0→7, position 0 = 7, wrap=1. Step coincident with tick → offset advances by exactly 1.
- HOLD/CLEAR: at offset=5, mode=00 for 20 cycles with steps → offset stays 5 while tick_out still pulses. mode=11 → offset 0 next cycle, prescaler restarts so the next tick is 4 cycles after returning to LEFT.
- Non-power-of-two: NUM_CH=5, SEL_W=3, mode LEFT → offset sequence 0,1,2,3,4,0, never 5..7. Load during an active tick → offset 0, no wrap.
- Async reset mid-scroll: drop Resetn between clock edges at offset=3 → outputs 0 immediately without waiting for a Clock edge.
